// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, latched request, port ids.
package dmem_arb_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 5;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the port that was not granted last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt,
  output logic valid
);

  assign valid = req0 | req1;
  assign gnt   = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the 32-word data memory (CPU port 0, DMA port 1).
// Optional grant counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic              busy,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`else
  output logic              busy
`endif
);

  state_e              state;
  req_t                req_l;
  logic                port_l;
  logic                last_grant;
  logic                gnt;
  logic                gnt_valid;
  logic [DATA_W-1:0]   rdata_q;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .gnt        (gnt),
    .valid      (gnt_valid)
  );

  // Inputs are only looked at in IDLE; the latched copy drives the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_DMA;
      port_l     <= PORT_CPU;
      req_l      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            port_l <= gnt;
            if (gnt == PORT_DMA) req_l <= '{we: we1, addr: addr1, wdata: wdata1};
            else                 req_l <= '{we: we0, addr: addr0, wdata: wdata0};
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (!req_l.we) rdata_q <= mem_rdata;
          state <= ACK;
        end
        ACK: begin
          last_grant <= port_l;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_re    = (state == ISSUE) & ~req_l.we;
  assign mem_we    = (state == ISSUE) &  req_l.we;
  assign mem_addr  = req_l.addr;
  assign mem_wdata = req_l.wdata;
  assign ack0      = (state == ACK) & (port_l == PORT_CPU);
  assign ack1      = (state == ACK) & (port_l == PORT_DMA);
  assign rdata     = rdata_q;
  assign busy      = (state != IDLE);

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (stats_clr) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (ack0) gnt_cnt0 <= sat_inc(gnt_cnt0);
      if (ack1) gnt_cnt1 <= sat_inc(gnt_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word memory model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;
  logic        mem_re, mem_we, busy;
`ifdef DMEM_ARB_STATS_EN
  logic                stats_clr;
  logic [TB_CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

  logic [31:0] mem [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
`ifdef DMEM_ARB_STATS_EN
    .busy      (busy),
    .stats_clr (stats_clr),
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`else
    .busy      (busy)
`endif
  );

  // Memory: synchronous write, read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int grant_seq [4];
  int n_acks;
  int both_acks;
  int stray_acks;

  initial begin
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    mem_rdata = '0;
    do_reset();

    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rdata", rdata, 0);

    // Port 0 write of 0xA to address 3.
    req0 = 1; we0 = 1; addr0 = 5'd3; wdata0 = 32'h0000000A;
    tick();
    chk("wr_issue_we", mem_we, 1);
    chk("wr_issue_re", mem_re, 0);
    chk("wr_issue_addr", mem_addr, 3);
    chk("wr_issue_wdata", mem_wdata, 32'hA);
    chk("wr_issue_busy", busy, 1);
    tick();
    chk("wr_wait_we", mem_we, 0);
    chk("wr_wait_ack0", ack0, 0);
    tick();
    chk("wr_ack0", ack0, 1);
    chk("wr_ack1", ack1, 0);
    req0 = 0;
    tick();
    chk("wr_idle_ack0", ack0, 0);
    chk("wr_idle_busy", busy, 0);

    // Port 0 read back of address 3.
    req0 = 1; we0 = 0; addr0 = 5'd3;
    tick();
    chk("rd_issue_re", mem_re, 1);
    chk("rd_issue_we", mem_we, 0);
    chk("rd_issue_addr", mem_addr, 3);
    tick();
    chk("rd_wait_re", mem_re, 0);
    tick();
    chk("rd_ack_re", mem_re, 0);
    chk("rd_ack0", ack0, 1);
    chk("rd_rdata", rdata, 32'hA);
    req0 = 0;
    tick();

    // Contention with last_grant=0: port 1 write wins, port 0 read follows.
    req1 = 1; we1 = 1; addr1 = 5'd7; wdata1 = 32'h55;
    req0 = 1; we0 = 0; addr0 = 5'd7;
    tick();
    chk("ct_issue_we", mem_we, 1);
    chk("ct_issue_addr", mem_addr, 7);
    chk("ct_issue_wdata", mem_wdata, 32'h55);
    tick();
    tick();
    chk("ct_ack1", ack1, 1);
    chk("ct_ack0_early", ack0, 0);
    req1 = 0;
    tick();
    chk("ct_idle_busy", busy, 0);
    tick();
    chk("ct_rd_issue_re", mem_re, 1);
    chk("ct_rd_issue_addr", mem_addr, 7);
    tick();
    tick();
    chk("ct_rd_ack0", ack0, 1);
    chk("ct_rd_ack1", ack1, 0);
    chk("ct_rd_rdata", rdata, 32'h55);
    req0 = 0;
    tick();

    // Both ports held high from reset: grants alternate starting with port 0.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 5'd3;
    req1 = 1; we1 = 0; addr1 = 5'd7;
    n_acks = 0; both_acks = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ack0 && ack1) both_acks++;
      else if (ack0 || ack1) begin
        if (n_acks < 4) grant_seq[n_acks] = ack1 ? 1 : 0;
        n_acks++;
      end
    end
    req0 = 0; req1 = 0;
    chk("rr_n_acks", n_acks, 4);
    chk("rr_both_acks", both_acks, 0);
    chk("rr_grant0", grant_seq[0], 0);
    chk("rr_grant1", grant_seq[1], 1);
    chk("rr_grant2", grant_seq[2], 0);
    chk("rr_grant3", grant_seq[3], 1);
    tick();

    // Finish a port 0 access so last_grant=0, then reset mid-access of port 1.
    req0 = 1; we0 = 0; addr0 = 5'd3;
    tick(); tick(); tick();
    chk("ab_pre_ack0", ack0, 1);
    req0 = 0;
    tick();
    req1 = 1; we1 = 1; addr1 = 5'd9; wdata1 = 32'h77;
    tick();
    chk("ab_issue_we", mem_we, 1);
    tick();
    chk("ab_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ab_rst_ack0", ack0, 0);
    chk("ab_rst_ack1", ack1, 0);
    chk("ab_rst_busy", busy, 0);
    chk("ab_rst_mem_re", mem_re, 0);
    chk("ab_rst_mem_we", mem_we, 0);
    chk("ab_rst_rdata", rdata, 0);
    chk("ab_rst_mem_addr", mem_addr, 0);
    chk("ab_rst_mem_wdata", mem_wdata, 0);
    req1 = 0;
    tick(); tick();
    rst_n = 1'b1;
    stray_acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 || ack1 || busy) stray_acks++;
    end
    chk("ab_no_ack", stray_acks, 0);
    req0 = 1; we0 = 0; addr0 = 5'd3;
    req1 = 1; we1 = 0; addr1 = 5'd7;
    tick(); tick(); tick();
    chk("ab_tie_ack0", ack0, 1);
    chk("ab_tie_ack1", ack1, 0);
    req0 = 0; req1 = 0;
    tick();

`ifdef DMEM_ARB_STATS_EN
    // Five port 0 grants saturate a 2-bit counter; clear takes it back to 0.
    do_reset();
    chk("st_rst_cnt0", gnt_cnt0, 0);
    req0 = 1; we0 = 0; addr0 = 5'd3;
    for (int i = 0; i < 20; i++) tick();
    req0 = 0;
    chk("st_cnt0_sat", gnt_cnt0, 3);
    chk("st_cnt1", gnt_cnt1, 0);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_cnt0_clr", gnt_cnt0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
